// File: rtl/rhd_pkg.sv
// Shared definitions for the RHD mode sequencer.
//   state_e          : sequencer state encoding, also driven on the state output
//   *_DEF            : default timing parameters (clk cycles / CS frames)
//   FRAME_CNT_W      : width of the CS frame counter
//   PULSE_CNT_W      : width of the start-pulse cycle counter
package rhd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_PULSE = 3'd1,
    ST_CFG_WAIT  = 3'd2,
    ST_ZC_PULSE  = 3'd3,
    ST_ZC_WAIT   = 3'd4,
    ST_REC       = 3'd5,
    ST_REC_STOP  = 3'd6
  } state_e;

  localparam int PULSE_CYCLES_DEF = 56;   // ~500 ns at 112 MHz
  localparam int CFG_FRAMES_DEF   = 70;
  localparam int ZC_FRAMES_DEF    = 200;

  localparam int FRAME_CNT_W = 16;
  localparam int PULSE_CNT_W = 16;

endpackage

// File: rtl/rhd_frame_counter.sv
// Counts CS rising edges and flags the edge that reaches a target count.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count from zero (edge in this cycle is not counted)
//   cs       : chip select from the rhd_2048 controller (same clock domain)
//   target   : number of rising edges to wait for
//   hit      : high in the cycle of the rising edge that completes the target
module rhd_frame_counter
  import rhd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   cs,
  input  logic [FRAME_CNT_W-1:0] target,
  output logic                   hit
);

  localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

  logic                   cs_q, cs_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   cs_rise;

  always_comb begin
    cs_d    = cs;
    cs_rise = cs & ~cs_q;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cs_rise && (cnt_q != '1)) begin
      // Saturate so a long recording cannot wrap into a false hit.
      cnt_d = cnt_q + CNT_ONE;
    end
    // hit uses the registered count only, so it never depends on clr
    // (clr is derived from the next state, which depends on hit).
    hit = cs_rise && ((cnt_q + CNT_ONE) == target);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      cs_q  <= cs_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rhd_mode_sequencer.sv
// Mode sequencer for an rhd_2048 controller: runs chip configuration,
// impedance-check sweeps over a channel range, and recording.
//   clk, rst                : clock, asynchronous active-high reset
//   cmd_config, cmd_zcheck  : single-cycle requests (config wins over zcheck)
//   rec_en                  : level request, record while high
//   abort                   : single-cycle, return to IDLE from anywhere
//   zc_first/zc_last/zc_scale : sweep bounds and scale, latched at sweep start
//   CS                      : controller chip select, rising edge = end of frame
//   config_start/zcheck_start/record_start : controller start inputs
//   zcheck_chip_channel/zcheck_scale       : controller zcheck inputs
//   busy, configured, zc_ch_done, err, state : status
module rhd_mode_sequencer
  import rhd_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int CFG_FRAMES   = CFG_FRAMES_DEF,
  parameter int ZC_FRAMES    = ZC_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_config,
  input  logic       cmd_zcheck,
  input  logic       rec_en,
  input  logic       abort,
  input  logic [6:0] zc_first,
  input  logic [6:0] zc_last,
  input  logic [1:0] zc_scale,
  input  logic       CS,
  output logic       config_start,
  output logic       zcheck_start,
  output logic       record_start,
  output logic [6:0] zcheck_chip_channel,
  output logic [1:0] zcheck_scale,
  output logic       busy,
  output logic       configured,
  output logic       zc_ch_done,
  output logic       err,
  output logic [2:0] state
);

  localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [PULSE_CNT_W-1:0] PULSE_ONE  = PULSE_CNT_W'(1);

  state_e                 state_q, state_d;
  logic [PULSE_CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                   configured_q, configured_d;
  logic                   err_q, err_d;
  logic                   zc_done_q, zc_done_d;
  logic [6:0]             ch_q, ch_d;
  logic [6:0]             last_q, last_d;
  logic [1:0]             scale_q, scale_d;
  logic                   rec_block_q, rec_block_d;

  logic                   rec_reject;
  logic                   pulse_done;
  logic                   frame_clr;
  logic                   frame_hit;
  logic [FRAME_CNT_W-1:0] frame_target;

  rhd_frame_counter u_frame_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (frame_clr),
    .cs     (CS),
    .target (frame_target),
    .hit    (frame_hit)
  );

  always_comb begin
    unique case (state_q)
      ST_CFG_WAIT: frame_target = FRAME_CNT_W'(CFG_FRAMES);
      ST_ZC_WAIT:  frame_target = FRAME_CNT_W'(ZC_FRAMES);
      ST_REC_STOP: frame_target = FRAME_CNT_W'(1);
      default:     frame_target = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    configured_d = configured_q;
    err_d        = 1'b0;
    zc_done_d    = 1'b0;
    ch_d         = ch_q;
    last_d       = last_q;
    scale_d      = scale_q;
    rec_reject   = 1'b0;
    pulse_done   = (pulse_cnt_q == PULSE_LAST);

    if (abort) begin
      // Abort wins over everything, including a command arriving in IDLE.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_config) begin
            state_d = ST_CFG_PULSE;
          end else if (cmd_zcheck) begin
            if (configured_q) begin
              state_d = ST_ZC_PULSE;
              ch_d    = zc_first;
              // An inverted range collapses to the single channel zc_first.
              last_d  = (zc_last < zc_first) ? zc_first : zc_last;
              scale_d = zc_scale;
            end else begin
              err_d = 1'b1;
            end
          end else if (rec_en && !rec_block_q) begin
            if (configured_q) begin
              state_d = ST_REC;
            end else begin
              err_d      = 1'b1;
              rec_reject = 1'b1;
            end
          end
        end
        ST_CFG_PULSE: if (pulse_done) state_d = ST_CFG_WAIT;
        ST_CFG_WAIT: begin
          if (frame_hit) begin
            state_d      = ST_IDLE;
            configured_d = 1'b1;
          end
        end
        ST_ZC_PULSE: if (pulse_done) state_d = ST_ZC_WAIT;
        ST_ZC_WAIT: begin
          if (frame_hit) begin
            zc_done_d = 1'b1;
            if (ch_q == last_q) begin
              state_d = ST_IDLE;
            end else begin
              // ch_q < last_q <= 127 here, so this never wraps.
              ch_d    = ch_q + 7'd1;
              state_d = ST_ZC_PULSE;
            end
          end
        end
        ST_REC:      if (!rec_en) state_d = ST_REC_STOP;
        ST_REC_STOP: if (frame_hit) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end

    // A rejected recording request stays rejected until rec_en drops.
    rec_block_d = rec_en & (rec_block_q | rec_reject);

    frame_clr = (state_d != state_q);
    if (frame_clr || !((state_q == ST_CFG_PULSE) || (state_q == ST_ZC_PULSE))) begin
      pulse_cnt_d = '0;
    end else begin
      pulse_cnt_d = pulse_cnt_q + PULSE_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pulse_cnt_q  <= '0;
      configured_q <= 1'b0;
      err_q        <= 1'b0;
      zc_done_q    <= 1'b0;
      ch_q         <= '0;
      last_q       <= '0;
      scale_q      <= '0;
      rec_block_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_cnt_q  <= pulse_cnt_d;
      configured_q <= configured_d;
      err_q        <= err_d;
      zc_done_q    <= zc_done_d;
      ch_q         <= ch_d;
      last_q       <= last_d;
      scale_q      <= scale_d;
      rec_block_q  <= rec_block_d;
    end
  end

  // Start outputs drop combinationally in the abort cycle itself.
  assign config_start        = (state_q == ST_CFG_PULSE) & ~abort;
  assign zcheck_start        = (state_q == ST_ZC_PULSE) & ~abort;
  assign record_start        = (state_q == ST_REC) & rec_en & ~abort;
  assign zcheck_chip_channel = ch_q;
  assign zcheck_scale        = scale_q;
  assign busy                = (state_q != ST_IDLE);
  assign configured          = configured_q;
  assign zc_ch_done          = zc_done_q;
  assign err                 = err_q;
  assign state               = state_q;

endmodule

// File: tb/tb_rhd_mode_sequencer.sv
module tb_rhd_mode_sequencer;

  localparam int PC = 56;
  localparam int CF = 70;
  localparam int ZF = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_config = 1'b0, cmd_zcheck = 1'b0, rec_en = 1'b0, abort = 1'b0;
  logic [6:0] zc_first = '0, zc_last = '0;
  logic [1:0] zc_scale = '0;
  logic       CS = 1'b0;
  logic [1:0] cs_div = '0;

  logic       config_start, zcheck_start, record_start;
  logic [6:0] zcheck_chip_channel;
  logic [1:0] zcheck_scale;
  logic       busy, configured, zc_ch_done, err;
  logic [2:0] state;

  rhd_mode_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_config          (cmd_config),
    .cmd_zcheck          (cmd_zcheck),
    .rec_en              (rec_en),
    .abort               (abort),
    .zc_first            (zc_first),
    .zc_last             (zc_last),
    .zc_scale            (zc_scale),
    .CS                  (CS),
    .config_start        (config_start),
    .zcheck_start        (zcheck_start),
    .record_start        (record_start),
    .zcheck_chip_channel (zcheck_chip_channel),
    .zcheck_scale        (zcheck_scale),
    .busy                (busy),
    .configured          (configured),
    .zc_ch_done          (zc_ch_done),
    .err                 (err),
    .state               (state)
  );

  initial forever #5 clk = ~clk;

  // CS frame generator: one rising edge every 4 clocks.
  initial forever begin
    @(posedge clk); #1;
    cs_div = cs_div + 2'd1;
    CS = cs_div[1];
  end

  // ---------------- behavioural model ----------------
  // op: 0 none, 1 configuration, 2 impedance sweep, 3 recording
  int m_op = 0, m_left = 0, m_ch = 0, m_last = 0, m_scale = 0;
  bit m_pulse = 0, m_stop = 0, m_cfgd = 0, m_err = 0, m_done = 0, m_block = 0, m_pcs = 0;
  bit m_edge, m_rej;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_op = 0; m_left = 0; m_ch = 0; m_last = 0; m_scale = 0;
      m_pulse = 0; m_stop = 0; m_cfgd = 0; m_err = 0; m_done = 0; m_block = 0; m_pcs = 0;
    end else begin
      m_edge = CS && !m_pcs;
      m_pcs  = CS;
      m_err = 0; m_done = 0; m_rej = 0;
      if (abort) m_op = 0;
      else if (m_op == 0) begin
        if (cmd_config) begin m_op = 1; m_pulse = 1; m_left = PC; end
        else if (cmd_zcheck) begin
          if (m_cfgd) begin
            m_op = 2; m_pulse = 1; m_left = PC; m_ch = zc_first; m_scale = zc_scale;
            m_last = (zc_last < zc_first) ? int'(zc_first) : int'(zc_last);
          end else m_err = 1;
        end else if (rec_en && !m_block) begin
          if (m_cfgd) begin m_op = 3; m_stop = 0; end
          else begin m_err = 1; m_rej = 1; end
        end
      end else if (m_op == 1 || m_op == 2) begin
        if (m_pulse) begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_pulse = 0; m_left = (m_op == 1) ? CF : ZF; end
        end else if (m_edge) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_op == 1) begin m_cfgd = 1; m_op = 0; end
            else begin
              m_done = 1;
              if (m_ch == m_last) m_op = 0;
              else begin m_ch = m_ch + 1; m_pulse = 1; m_left = PC; end
            end
          end
        end
      end else begin
        if (!m_stop) begin if (!rec_en) m_stop = 1; end
        else if (m_edge) m_op = 0;
      end
      m_block = rec_en && (m_block || m_rej);
    end
  end

  function automatic logic [2:0] m_code();
    case (m_op)
      1:       return m_pulse ? 3'd1 : 3'd2;
      2:       return m_pulse ? 3'd3 : 3'd4;
      3:       return m_stop ? 3'd6 : 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // ---------------- compare process and monitors ----------------
  int n_vec = 0, n_bad = 0;
  bit lit_req = 0;
  string lit_name = "";
  int lit_got = 0, lit_exp = 0;

  int cs_rise_cnt = 0, cfg_hi_cnt = 0, zcs_hi_cnt = 0, done_cnt = 0, err_cnt = 0, rec_hi_cnt = 0;
  bit rise_now = 0, mon_pcs = 0, mon_pzs = 0;
  logic [8:0] zlog[$];
  logic [18:0] got_v, exp_v;

  initial forever begin
    @(negedge clk);
    exp_v = {(m_op == 1) && m_pulse && !abort, (m_op == 2) && m_pulse && !abort,
             (m_op == 3) && !m_stop && rec_en && !abort, 7'(m_ch), 2'(m_scale),
             m_op != 0, m_cfgd, m_done, m_err, m_code()};
    got_v = {config_start, zcheck_start, record_start, zcheck_chip_channel, zcheck_scale,
             busy, configured, zc_ch_done, err, state};
    n_vec++;
    if (got_v !== exp_v) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL outputs @%0t: got %05h, expected %05h", $time, got_v, exp_v);
    end
    if (lit_req) begin
      n_vec++;
      if (lit_got != lit_exp) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d", lit_name, lit_got, lit_exp);
      end
    end
    rise_now = CS && !mon_pcs;
    mon_pcs  = CS;
    cs_rise_cnt += int'(rise_now);
    cfg_hi_cnt  += int'(config_start);
    zcs_hi_cnt  += int'(zcheck_start);
    done_cnt    += int'(zc_ch_done);
    err_cnt     += int'(err);
    rec_hi_cnt  += int'(record_start);
    if (zcheck_start && !mon_pzs) zlog.push_back({zcheck_scale, zcheck_chip_channel});
    mon_pzs = zcheck_start;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input int got, input int exp);
    lit_name = name; lit_got = got; lit_exp = exp; lit_req = 1'b1;
    @(negedge clk); #1;
    lit_req = 1'b0;
  endtask

  task automatic do_sweep(input int f, input int l, input int s, output bit to);
    zc_first = 7'(f); zc_last = 7'(l); zc_scale = 2'(s);
    cyc(); cmd_zcheck = 1'b1;
    cyc(); cmd_zcheck = 1'b0;
    // scramble the bounds: the sweep must use the latched copies
    zc_first = 7'd0; zc_last = 7'd127; zc_scale = 2'd0;
    to = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      cyc();
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  int  e0, c0, z0, d0, d1, q0, r0, n;
  bit  to, b, rs, rs_after, zs, cf, rn;
  int  st;

  initial begin
    // reset
    repeat (4) cyc();
    lit("rst_state", int'(state), 0);
    lit("rst_busy", int'(busy), 0);
    lit("rst_configured", int'(configured), 0);
    lit("rst_channel", int'(zcheck_chip_channel), 0);
    rst = 1'b0;
    cyc();

    // requests before configuration are rejected
    e0 = err_cnt; r0 = rec_hi_cnt;
    rec_en = 1'b1;
    repeat (6) cyc();
    rec_en = 1'b0;
    cyc();
    cmd_zcheck = 1'b1; cyc(); cmd_zcheck = 1'b0; cyc(); cyc();
    lit("noconfig_err_pulses", err_cnt - e0, 2);
    lit("noconfig_record_start", rec_hi_cnt - r0, 0);
    lit("noconfig_busy", int'(busy), 0);

    // config and zcheck together: config runs, zcheck dropped
    c0 = cfg_hi_cnt; z0 = zcs_hi_cnt;
    cmd_config = 1'b1; cmd_zcheck = 1'b1; zc_first = 7'd1; zc_last = 7'd2;
    cyc(); cmd_config = 1'b0; cmd_zcheck = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin cyc(); if (!config_start) begin to = 1'b0; break; end end
    e0 = cs_rise_cnt;
    for (int i = 0; i < 2000 && !to; i++) begin cyc(); if (configured) break; end
    b = busy; n = cs_rise_cnt - e0; cf = configured;
    lit("cfg_timeout", int'(to), 0);
    lit("cfg_configured", int'(cf), 1);
    lit("cfg_edges", n, 70);
    lit("cfg_busy_same_cycle", int'(b), 0);
    lit("cfg_pulse_len", cfg_hi_cnt - c0, 56);
    lit("cfg_zcheck_dropped", zcs_hi_cnt - z0, 0);

    // sweep 61..63 at scale 3
    q0 = zlog.size(); d0 = done_cnt; z0 = zcs_hi_cnt;
    do_sweep(61, 63, 3, to);
    lit("sweep_timeout", int'(to), 0);
    lit("sweep_done_pulses", done_cnt - d0, 3);
    lit("sweep_start_pulses", zlog.size() - q0, 3);
    for (int i = 0; i < 3; i++)
      lit("sweep_scale_chan", (q0 + i < zlog.size()) ? int'(zlog[q0 + i]) : -1, (3 << 7) | (61 + i));
    lit("sweep_start_cycles", zcs_hi_cnt - z0, 3 * 56);

    // recording
    cyc(); rec_en = 1'b1;
    repeat (8) cyc();
    rs = record_start;
    rec_en = 1'b0; #1;
    rs_after = record_start; b = busy;
    to = 1'b1; n = 0; rn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(); n++;
      if (!busy) begin to = 1'b0; break; end
      rn = rise_now;
    end
    rn = rise_now;
    lit("rec_on", int'(rs), 1);
    lit("rec_off_immediate", int'(rs_after), 0);
    lit("rec_busy_in_stop", int'(b), 1);
    lit("rec_stop_timeout", int'(to), 0);
    lit("rec_stop_on_cs_edge", int'(rn), 1);
    lit("rec_stop_within_frame", int'(n <= 5), 1);

    // abort during ZC_WAIT at channel 62
    d0 = done_cnt;
    zc_first = 7'd61; zc_last = 7'd63; zc_scale = 2'd1;
    cyc(); cmd_zcheck = 1'b1; cyc(); cmd_zcheck = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (zcheck_chip_channel == 7'd62 && !zcheck_start && busy) begin to = 1'b0; break; end
    end
    repeat (20) cyc();
    abort = 1'b1; #1; zs = zcheck_start;
    cyc(); abort = 1'b0;
    st = int'(state); b = busy; cf = configured; d1 = done_cnt;
    repeat (1000) cyc();
    lit("abort_wait_timeout", int'(to), 0);
    lit("abort_zcheck_start", int'(zs), 0);
    lit("abort_state", st, 0);
    lit("abort_busy", int'(b), 0);
    lit("abort_configured", int'(cf), 1);
    lit("abort_done_before", d1 - d0, 1);
    lit("abort_no_more_done", done_cnt - d1, 0);

    // abort during ZC_PULSE drops zcheck_start in the same cycle
    zc_first = 7'd20; zc_last = 7'd20;
    cyc(); cmd_zcheck = 1'b1; cyc(); cmd_zcheck = 1'b0;
    repeat (5) cyc();
    abort = 1'b1; #1; zs = zcheck_start; b = busy;
    cyc(); abort = 1'b0; st = int'(state);
    lit("abort_pulse_start", int'(zs), 0);
    lit("abort_pulse_busy", int'(b), 1);
    lit("abort_pulse_state", st, 0);

    // abort together with a command in IDLE
    c0 = cfg_hi_cnt;
    cyc(); cmd_config = 1'b1; abort = 1'b1;
    cyc(); cmd_config = 1'b0; abort = 1'b0;
    st = int'(state);
    cyc(); cyc();
    lit("abort_cmd_state", st, 0);
    lit("abort_cmd_dropped", cfg_hi_cnt - c0, 0);

    // inverted range: only zc_first swept
    q0 = zlog.size(); d0 = done_cnt;
    do_sweep(10, 5, 2, to);
    lit("single_timeout", int'(to), 0);
    lit("single_starts", zlog.size() - q0, 1);
    lit("single_chan", (q0 < zlog.size()) ? int'(zlog[q0]) : -1, (2 << 7) | 10);
    lit("single_done", done_cnt - d0, 1);

    // reset during CFG_WAIT
    cyc(); cmd_config = 1'b1; cyc(); cmd_config = 1'b0;
    for (int i = 0; i < 200; i++) begin cyc(); if (!config_start) break; end
    repeat (10) cyc();
    st = int'(state);
    lit("pre_rst_in_cfg_wait", st, 2);
    rst = 1'b1; #1;
    st = int'({config_start, zcheck_start, record_start, zcheck_chip_channel, zcheck_scale,
               busy, configured, zc_ch_done, err, state});
    repeat (2) cyc();
    rst = 1'b0;
    lit("rst_mid_outputs", st, 0);
    cyc();
    e0 = err_cnt;
    rec_en = 1'b1; repeat (4) cyc(); rec_en = 1'b0; cyc(); cyc();
    lit("rst_needs_reconfig", err_cnt - e0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rhd_mode_sequencer.md
RHD_MODE_SEQUENCER -- requirements
Module: rhd_mode_sequencer

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 56: start-pulse width in clk cycles (about 500 ns at 112 MHz).
REQ-002 SHALL have parameter CFG_FRAMES, default 70: CS frames to wait after config_start.
REQ-003 SHALL have parameter ZC_FRAMES, default 200: CS frames to wait per impedance-check channel.
REQ-004 clk  in  1  system clock (112 MHz).
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_config  in  1  single-cycle request: run chip configuration.
REQ-007 cmd_zcheck  in  1  single-cycle request: run impedance sweep.
REQ-008 rec_en  in  1  level: record while high.
REQ-009 abort  in  1  single-cycle request: terminate any operation.
REQ-010 zc_first, zc_last  in  7 each  inclusive sweep channel bounds.
REQ-011 zc_scale  in  2  impedance scale for the whole sweep.
REQ-012 CS  in  1  chip select from the rhd_2048 controller; one rising edge marks the end of one frame.
REQ-013 config_start, zcheck_start, record_start  out  1 each  drive the rhd_2048 start inputs.
REQ-014 zcheck_chip_channel  out  7  and  zcheck_scale  out  2  drive the rhd_2048 zcheck inputs.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 configured  out  1  sticky flag, set when a configuration completes.
REQ-017 zc_ch_done  out  1  one-cycle pulse per completed sweep channel.
REQ-018 err  out  1  one-cycle pulse when a request is rejected.
REQ-019 state  out  3  current state encoding.

Function
REQ-020 States SHALL be IDLE, CFG_PULSE, CFG_WAIT, ZC_PULSE, ZC_WAIT, REC, REC_STOP.
REQ-021 In IDLE, priority SHALL be cmd_config > cmd_zcheck > rec_en; requests that arrive while busy (other than abort) SHALL be dropped without err.
REQ-022 cmd_zcheck or rec_en in IDLE while configured=0 SHALL pulse err for one cycle and stay in IDLE; rec_en SHALL then be ignored until it falls and rises again.
REQ-023 CFG_PULSE SHALL hold config_start=1 for exactly PULSE_CYCLES cycles, then enter CFG_WAIT with config_start=0.
REQ-024 CFG_WAIT SHALL count CS rising edges (one-register edge detector, same clock domain); at CFG_FRAMES edges it SHALL set configured and return to IDLE.
REQ-025 On sweep start, zc_first and zc_scale SHALL be latched; the channel register SHALL drive zcheck_chip_channel, and zcheck_scale SHALL stay stable throughout the sweep.
REQ-026 ZC_PULSE SHALL hold zcheck_start=1 for PULSE_CYCLES cycles, then enter ZC_WAIT.
REQ-027 ZC_WAIT SHALL count ZC_FRAMES CS edges, then pulse zc_ch_done; if channel == latched zc_last it SHALL go to IDLE, otherwise it SHALL increment the channel and go to ZC_PULSE.
REQ-028 If zc_last < zc_first at sweep start, exactly one channel (zc_first) SHALL be swept; the channel counter SHALL never wrap 127→0.
REQ-029 REC SHALL hold record_start=1 while rec_en=1; when rec_en falls it SHALL enter REC_STOP with record_start=0, then go to IDLE on the next CS rising edge.
REQ-030 abort SHALL move any state to IDLE on the next edge, deassert all start outputs in that cycle, and leave configured unchanged.
REQ-031 abort together with a command in IDLE SHALL give abort precedence, and the command SHALL be dropped.
REQ-032 The frame counter SHALL be 16 bits and clear on every state entry; the pulse counter SHALL clear on every entry to a pulse state.

Reset
REQ-033 While rst=1: state=IDLE; all start outputs, busy, configured, zc_ch_done and err = 0; zcheck_chip_channel=0; zcheck_scale=0; all counters = 0.
REQ-034 rst asserted mid-operation SHALL clear configured, so a new configuration is required.

Structure
REQ-035 The state encoding and default parameter values SHALL live in the shared package rhd_pkg.
REQ-036 A single sub-module, rhd_frame_counter (CS edge detect plus target-count compare, with clear input), SHALL be used.

Verification
REQ-037 Reset, then cmd_config → config_start high 56 cycles; configured=1 after the 70th CS edge; busy falls in the same cycle.
REQ-038 cmd_zcheck with first=61, last=63, scale=3 → three zcheck_start pulses on channels 61, 62, 63; 3 zc_ch_done pulses; zcheck_scale=3 throughout.
REQ-039 rec_en before any config → err pulse, record_start stays 0; after config, rec_en 1→0 → record_start falls immediately and busy clears at the next CS edge.
REQ-040 abort during ZC_WAIT at channel 62 → IDLE next cycle, zcheck_start=0, configured stays 1, no further zc_ch_done.
REQ-041 cmd_config and cmd_zcheck in the same cycle → config runs and the zcheck is dropped; a sweep with first=10, last=5 → one channel (10) only.
REQ-042 rst asserted during CFG_WAIT → all outputs at reset values and configured=0.
